pipelined_adder: RTL and testbench

- Parametrised successor of the team's single-cycle registered adder.
- Adds two unsigned WIDTH-bit operands, or subtracts them, selected per transaction.
- The result passes through a STAGES-deep register pipeline with full valid/ready backpressure.
- Sits between an operand producer and a result consumer in the datapath; every accepted transaction produces exactly one result, in order.

---
 rtl/adder_pkg.sv | 14 +
 rtl/pipelined_adder_if.sv | 28 ++
 rtl/adder_pipe_stage.sv | 33 +++
 rtl/pipelined_adder.sv | 54 +++++
 tb/tb_pipelined_adder.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// Shared types for the pipelined adder: operation encoding and result width.
package adder_pkg;

   typedef enum logic {
      OP_ADD = 1'b0,
      OP_SUB = 1'b1
   } op_e;

   // One extra bit carries the add carry-out or the subtract borrow.
   function automatic int res_width(input int width);
      return width + 1;
   endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle between producer, adder and consumer.
interface pipelined_adder_if
   import adder_pkg::*;
#(
   parameter int WIDTH = 9
);
   localparam int RW = res_width(WIDTH);

   logic [WIDTH-1:0] data_in0;
   logic [WIDTH-1:0] data_in1;
   op_e              op_in;
   logic             in_valid;
   logic             in_ready;
   logic [RW-1:0]    data_out;
   logic             out_valid;
   logic             out_ready;

   modport master (
      output data_in0, data_in1, op_in, in_valid, out_ready,
      input  in_ready, data_out, out_valid
   );

   modport slave (
      input  data_in0, data_in1, op_in, in_valid, out_ready,
      output in_ready, data_out, out_valid
   );

endinterface

// File: rtl/adder_pipe_stage.sv
// One valid/ready register stage; loads zero data when the upstream slot is empty.
module adder_pipe_stage #(
   parameter int DW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_valid,
   input  logic [DW-1:0] i_data,
   input  logic          i_ready_dn,
   output logic          o_ready,
   output logic          o_valid,
   output logic [DW-1:0] o_data
);

   logic          r_valid;
   logic [DW-1:0] r_data;

   // Combinational ready chain: an empty slot or a draining downstream frees this stage.
   assign o_ready = !r_valid || i_ready_dn;
   assign o_valid = r_valid;
   assign o_data  = r_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (o_ready) begin
         r_valid <= i_valid;
         r_data  <= i_valid ? i_data : '0;
      end
   end

endmodule

// File: rtl/pipelined_adder.sv
// Unsigned add/subtract computed ahead of stage 0, then carried through STAGES registers.
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = 9,
   parameter int STAGES = 2
) (
   input logic               clk,
   input logic               rst,
   pipelined_adder_if.slave  bus
);

   localparam int RW = res_width(WIDTH);

   logic [RW-1:0] w_result;
   logic [STAGES:0] w_valid;
   logic [STAGES:0] w_ready;
   logic [RW-1:0] w_data [0:STAGES];

   // SUB wraps modulo 2^RW, so the top bit doubles as the borrow flag.
   always_comb begin
      w_result = '0;
      if (bus.op_in == OP_SUB) begin
         w_result = {1'b0, bus.data_in0} - {1'b0, bus.data_in1};
      end else begin
         w_result = {1'b0, bus.data_in0} + {1'b0, bus.data_in1};
      end
   end

   assign w_valid[0]      = bus.in_valid;
   assign w_data[0]       = w_result;
   assign w_ready[STAGES] = bus.out_ready;
   assign bus.in_ready    = w_ready[0];
   assign bus.out_valid   = w_valid[STAGES];
   assign bus.data_out    = w_data[STAGES];

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
         adder_pipe_stage #(
            .DW (RW)
         ) u_stage (
            .clk        (clk),
            .rst        (rst),
            .i_valid    (w_valid[gi]),
            .i_data     (w_data[gi]),
            .i_ready_dn (w_ready[gi+1]),
            .o_ready    (w_ready[gi]),
            .o_valid    (w_valid[gi+1]),
            .o_data     (w_data[gi+1])
         );
      end
   endgenerate

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: directed cases plus randomized streaming and stalls.
module tb_pipelined_adder;
   import adder_pkg::*;

   localparam int W = 9;
   localparam int S = 2;
   localparam int MOD = 1 << (W + 1);

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pipelined_adder_if #(.WIDTH(W)) bus ();

   pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int exp_q[$];
   int out_cnt  = 0;

   function automatic int model(input int a, input int b, input bit sub);
      if (sub) return ((a - b) % MOD + MOD) % MOD;
      return a + b;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input int a, input int b, input bit sub, input bit v);
      bus.data_in0 = W'(a);
      bus.data_in1 = W'(b);
      bus.op_in    = sub ? OP_SUB : OP_ADD;
      bus.in_valid = v;
   endtask

   // Monitor: check outputs against the queue, then record newly accepted inputs.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL sb_extra: got unexpected result %0d, expected none", bus.data_out);
            end else begin
               check("sb_data", int'(bus.data_out), exp_q.pop_front());
            end
         end
         if (!bus.out_valid) check("idle_zero", int'(bus.data_out), 0);
         if (bus.in_valid && bus.in_ready)
            exp_q.push_back(model(int'(bus.data_in0), int'(bus.data_in1), bus.op_in == OP_SUB));
      end
   end

   task automatic drain(input string name);
      int c;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      c = 0;
      while (exp_q.size() != 0 && c < 50) begin
         @(posedge clk); #1;
         c++;
      end
      @(posedge clk); #1;
      check(name, exp_q.size(), 0);
   endtask

   initial begin
      int k, base, first, lowready, loop_outs, acc;
      bit holding;

      rst = 1'b1;
      bus.out_ready = 1'b1;
      set_in(0, 0, 0, 0);
      @(posedge clk); #1;
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_data_out", int'(bus.data_out), 0);
      check("rst_in_ready", int'(bus.in_ready), 1);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // 1: max add, latency 2
      set_in(511, 511, 0, 1);
      @(posedge clk); #1;
      set_in(0, 0, 0, 0);
      check("t1_early_valid", int'(bus.out_valid), 0);
      @(posedge clk); #1;
      check("t1_valid", int'(bus.out_valid), 1);
      check("t1_data", int'(bus.data_out), 1022);
      @(posedge clk); #1;
      check("t1_after_valid", int'(bus.out_valid), 0);
      check("t1_after_data", int'(bus.data_out), 0);

      // 2: subtract both signs back-to-back
      set_in(7, 5, 1, 1);
      @(posedge clk); #1;
      set_in(5, 7, 1, 1);
      @(posedge clk); #1;
      set_in(0, 0, 0, 0);
      check("t2_pos", int'(bus.data_out), 2);
      @(posedge clk); #1;
      check("t2_neg", int'(bus.data_out), 10'h3FE);
      drain("t2_drain");

      // 3: backpressure
      base = out_cnt;
      bus.out_ready = 1'b0;
      k = 1;
      for (int c = 0; c < 6; c++) begin
         set_in(k, k, 0, 1);
         @(negedge clk);
         if (bus.in_ready) k++;
         @(posedge clk); #1;
      end
      check("t3_accepts", k - 1, 2);
      check("t3_in_ready", int'(bus.in_ready), 0);
      check("t3_out_valid", int'(bus.out_valid), 1);
      check("t3_held", int'(bus.data_out), 2);
      bus.out_ready = 1'b1;
      for (int c = 0; c < 10 && k <= 3; c++) begin
         set_in(k, k, 0, 1);
         @(negedge clk);
         if (bus.in_ready) k++;
         @(posedge clk); #1;
      end
      drain("t3_drain");
      check("t3_out_count", out_cnt - base, 3);

      // 4: streaming at full rate
      base = out_cnt; first = -1; lowready = 0; loop_outs = 0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         set_in(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), 1);
         @(negedge clk);
         if (!bus.in_ready) lowready++;
         if (bus.out_valid) begin
            loop_outs++;
            if (first < 0) first = c;
         end
         @(posedge clk); #1;
      end
      drain("t4_drain");
      check("t4_in_ready_low", lowready, 0);
      check("t4_first_cycle", first, 2);
      check("t4_loop_outs", loop_outs, 18);
      check("t4_out_count", out_cnt - base, 20);

      // 5: reset mid-flight
      bus.out_ready = 1'b0;
      set_in(100, 3, 0, 1);
      @(posedge clk); #1;
      set_in(50, 60, 1, 1);
      @(posedge clk); #1;
      set_in(0, 0, 0, 0);
      check("t5_inflight", int'(bus.out_valid), 1);
      #2 rst = 1'b1;
      #1;
      check("t5_rst_valid", int'(bus.out_valid), 0);
      check("t5_rst_data", int'(bus.data_out), 0);
      @(negedge clk); @(posedge clk); @(negedge clk);
      rst = 1'b0;
      bus.out_ready = 1'b1;
      loop_outs = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         if (bus.out_valid) loop_outs++;
      end
      check("t5_no_stale", loop_outs, 0);
      @(posedge clk); #1;
      set_in(10, 20, 0, 1);
      @(posedge clk); #1;
      set_in(0, 0, 0, 0);
      @(posedge clk); #1;
      check("t5_new_valid", int'(bus.out_valid), 1);
      check("t5_new_data", int'(bus.data_out), 30);
      drain("t5_drain");

      // 6: random valid/ready stalls
      base = out_cnt; acc = 0; holding = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         if (!holding)
            set_in(int'($urandom_range(0, 511)), int'($urandom_range(0, 511)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         bus.out_ready = ($urandom_range(0, 9) < 7);
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) acc++;
         holding = bus.in_valid && !bus.in_ready;
         @(posedge clk); #1;
      end
      drain("t6_drain");
      check("t6_lossless", out_cnt - base, acc);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
